// File: rtl/serial_pattern_gen_if.sv
// Load-side handshake bundle for serial_pattern_gen: the master offers a pattern, the slave accepts it.
interface serial_pattern_gen_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  localparam int NB = $clog2(WIDTH + 1);

  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] pattern;
  logic [NB-1:0]    nbits;
  logic [CNT_W-1:0] repeat_cnt;

  modport master (output load_valid, pattern, nbits, repeat_cnt, input load_ready);
  modport slave  (input load_valid, pattern, nbits, repeat_cnt, output load_ready);
endinterface

// File: rtl/serial_pattern_gen.sv
// Serial MSB-first pattern transmitter with repeat count and idle gaps between repetitions.
// Optional trailing even-parity bit per repetition when SERIAL_PATTERN_GEN_PARITY_EN is defined.
module serial_pattern_gen #(
  parameter int WIDTH      = 8,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 4
) (
  input  logic                clock,
  input  logic                reset,
  serial_pattern_gen_if.slave ld,
  output logic                dout,
  output logic                dout_valid,
  output logic                busy,
  output logic                done
);
  localparam int NB = $clog2(WIDTH + 1);
`ifdef SERIAL_PATTERN_GEN_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n, pat_l, pat_l_n;
  logic [NB-1:0]    nb_l, nb_l_n, bitcnt, bitcnt_n, eff;
  logic [CNT_W-1:0] rep_left, rep_left_n;
  logic [3:0]       gapcnt, gapcnt_n;
  logic             par_acc, par_acc_n, par_phase, par_phase_n;
  logic             dout_n, dout_valid_n, done_n, reload;

  assign eff = (ld.nbits == '0 || ld.nbits > NB'(WIDTH)) ? NB'(WIDTH) : ld.nbits;

  // dout holds the bit of the current cycle; sreg holds only the bits still to come
  always_comb begin
    state_n      = state;
    sreg_n       = sreg;
    pat_l_n      = pat_l;
    nb_l_n       = nb_l;
    bitcnt_n     = bitcnt;
    rep_left_n   = rep_left;
    gapcnt_n     = gapcnt;
    par_acc_n    = par_acc;
    par_phase_n  = par_phase;
    dout_n       = 1'b0;
    dout_valid_n = 1'b0;
    done_n       = 1'b0;
    reload       = 1'b0;
    case (state)
      IDLE: begin
        if (ld.load_valid && ld.load_ready) begin
          state_n      = SHIFT;
          pat_l_n      = ld.pattern;
          nb_l_n       = eff;
          rep_left_n   = ld.repeat_cnt;
          sreg_n       = ld.pattern << 1;
          bitcnt_n     = eff - NB'(1);
          dout_n       = ld.pattern[WIDTH-1];
          dout_valid_n = 1'b1;
          par_acc_n    = ld.pattern[WIDTH-1];
          par_phase_n  = 1'b0;
        end
      end
      SHIFT: begin
        if (!par_phase && bitcnt != '0) begin
          dout_n       = sreg[WIDTH-1];
          dout_valid_n = 1'b1;
          sreg_n       = sreg << 1;
          bitcnt_n     = bitcnt - NB'(1);
          par_acc_n    = par_acc ^ sreg[WIDTH-1];
        end else if (PARITY_EN && !par_phase) begin
          dout_n       = par_acc;
          dout_valid_n = 1'b1;
          par_phase_n  = 1'b1;
        end else if (rep_left != '0) begin
          if (GAP_CYCLES > 0) begin
            state_n  = GAP;
            gapcnt_n = 4'(GAP_CYCLES - 1);
          end else begin
            reload = 1'b1;
          end
        end else begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      GAP: begin
        if (gapcnt != '0) gapcnt_n = gapcnt - 4'd1;
        else              reload   = 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (reload) begin
      state_n      = SHIFT;
      sreg_n       = pat_l << 1;
      bitcnt_n     = nb_l - NB'(1);
      rep_left_n   = rep_left - CNT_W'(1);
      dout_n       = pat_l[WIDTH-1];
      dout_valid_n = 1'b1;
      par_acc_n    = pat_l[WIDTH-1];
      par_phase_n  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      sreg          <= '0;
      pat_l         <= '0;
      nb_l          <= '0;
      bitcnt        <= '0;
      rep_left      <= '0;
      gapcnt        <= '0;
      par_acc       <= 1'b0;
      par_phase     <= 1'b0;
      dout          <= 1'b0;
      dout_valid    <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
      ld.load_ready <= 1'b1;
    end else begin
      state         <= state_n;
      sreg          <= sreg_n;
      pat_l         <= pat_l_n;
      nb_l          <= nb_l_n;
      bitcnt        <= bitcnt_n;
      rep_left      <= rep_left_n;
      gapcnt        <= gapcnt_n;
      par_acc       <= par_acc_n;
      par_phase     <= par_phase_n;
      dout          <= dout_n;
      dout_valid    <= dout_valid_n;
      done          <= done_n;
      busy          <= (state_n != IDLE);
      ld.load_ready <= (state_n == IDLE);
    end
  end
endmodule
